// File: rtl/aes_sha3_host_if_pkg.sv
// Shared types and byte-count constants for the AES/SHA3 host interface.
package aes_sha3_host_if_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    KEY_TX      = 3'd1,
    KDF_WAIT_HI = 3'd2,
    KDF_WAIT_LO = 3'd3,
    MSG_WAIT    = 3'd4,
    MSG_TX      = 3'd5,
    RX          = 3'd6,
    RESULT      = 3'd7
  } state_t;

  localparam int KEY_BYTES    = 32;
  localparam int MSG_BYTES    = 16;
  localparam int CIPHER_BYTES = 16;
  localparam int TAG_BYTES    = 32;

  localparam logic [5:0] RX_LAST = 6'(CIPHER_BYTES + TAG_BYTES - 1);

  typedef struct packed {
    logic [8*TAG_BYTES-1:0]    tag;
    logic [8*CIPHER_BYTES-1:0] cipher;
  } result_t;

endpackage

// File: rtl/hostif_byte_ser.sv
// Parallel-to-serial byte shifter, MSB byte first; o_last flags the final byte of a load.
module hostif_byte_ser #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [5:0]       i_nbytes,
  input  logic             i_shift,
  output logic [7:0]       o_byte,
  output logic             o_last
);

  logic [WIDTH-1:0] r_sh;
  logic [5:0]       r_cnt;
  logic [5:0]       r_last_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh       <= '0;
      r_cnt      <= 6'd0;
      r_last_idx <= 6'd0;
    end else if (i_load) begin
      r_sh       <= i_data;
      r_cnt      <= 6'd0;
      r_last_idx <= i_nbytes - 6'd1;
    end else if (i_shift) begin
      r_sh  <= {r_sh[WIDTH-9:0], 8'h00};
      r_cnt <= r_cnt + 6'd1;
    end else begin
      r_sh <= r_sh;
    end
  end

  assign o_byte = r_sh[WIDTH-1 -: 8];
  assign o_last = (r_cnt == r_last_idx);

endmodule

// File: rtl/aes_sha3_host_if.sv
// Host-side byte-stream master for the AES/SHA3 core's 8-bit serial port.
// Optional watchdog on the core wait states is enabled by defining HOSTIF_TIMEOUT_EN.
module aes_sha3_host_if
  import aes_sha3_host_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [255:0] cfg_salt_key,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [127:0] msg_data,
  input  logic         msg_mode,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_cipher,
  output logic [255:0] res_tag,
  output logic [7:0]   core_data,
  output logic         core_start,
  output logic         core_mode,
  input  logic         core_ien,
  input  logic [7:0]   core_odata,
  input  logic         core_ovalid,
  output logic         err
);

  state_t       r_state, w_state_nxt;
  logic         r_cfg_ready, r_msg_ready, r_res_valid, r_core_start, r_core_mode, r_cfg_done;
  logic [7:0]   r_core_data;
  logic [5:0]   r_rx_cnt;
  result_t      r_res;
  logic         w_cfg_hs, w_msg_hs, w_res_hs, w_capture, w_rx_done, w_timeout;
  logic         w_ser_load, w_ser_shift, w_ser_last;
  logic [5:0]   w_ser_nbytes;
  logic [255:0] w_ser_data;
  logic [7:0]   w_ser_byte;
  logic [4:0]   w_tag_idx;

  assign w_cfg_hs  = (r_state == IDLE) && cfg_valid && r_cfg_ready;
  assign w_msg_hs  = (r_state == MSG_WAIT) && msg_valid && r_msg_ready;
  assign w_res_hs  = (r_state == RESULT) && res_ready;
  assign w_capture = (r_state == RX) && core_ovalid;
  assign w_rx_done = w_capture && (r_rx_cnt == RX_LAST);
  assign w_tag_idx = r_rx_cnt[4:0] - 5'd16;

  hostif_byte_ser #(.WIDTH(256)) u_ser (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_ser_load),
    .i_data   (w_ser_data),
    .i_nbytes (w_ser_nbytes),
    .i_shift  (w_ser_shift),
    .o_byte   (w_ser_byte),
    .o_last   (w_ser_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ser_load   = 1'b0;
    w_ser_shift  = 1'b0;
    w_ser_nbytes = 6'(MSG_BYTES);
    w_ser_data   = {msg_data, 128'h0};
    case (r_state)
      IDLE: begin
        // Only reachable with cfg already done after a watchdog abort.
        if (w_cfg_hs) begin
          w_state_nxt  = KEY_TX;
          w_ser_load   = 1'b1;
          w_ser_nbytes = 6'(KEY_BYTES);
          w_ser_data   = cfg_salt_key;
        end else if (r_cfg_done && !core_ien) begin
          w_state_nxt = MSG_WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      KEY_TX: begin
        w_ser_shift = 1'b1;
        if (w_ser_last) w_state_nxt = KDF_WAIT_HI;
        else            w_state_nxt = KEY_TX;
      end
      KDF_WAIT_HI: w_state_nxt = core_ien ? KDF_WAIT_LO : KDF_WAIT_HI;
      KDF_WAIT_LO: w_state_nxt = core_ien ? KDF_WAIT_LO : MSG_WAIT;
      MSG_WAIT: begin
        w_ser_load  = w_msg_hs;
        w_state_nxt = w_msg_hs ? MSG_TX : MSG_WAIT;
      end
      MSG_TX: begin
        w_ser_shift = 1'b1;
        if (w_ser_last) w_state_nxt = RX;
        else            w_state_nxt = MSG_TX;
      end
      RX:      w_state_nxt = w_rx_done ? RESULT : RX;
      RESULT:  w_state_nxt = w_res_hs ? MSG_WAIT : RESULT;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = IDLE;
    else           w_state_nxt = w_state_nxt;
  end

  // Handshake flags and core strobes are registered copies of next-state decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_ready  <= 1'b0;
      r_msg_ready  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_core_start <= 1'b0;
      r_core_data  <= 8'h00;
      r_core_mode  <= 1'b0;
      r_cfg_done   <= 1'b0;
    end else begin
      r_cfg_ready  <= (w_state_nxt == IDLE) && !r_cfg_done && !core_ien;
      r_msg_ready  <= (w_state_nxt == MSG_WAIT) && !core_ien;
      r_res_valid  <= (w_state_nxt == RESULT);
      r_core_start <= w_ser_shift;
      r_core_data  <= w_ser_shift ? w_ser_byte : 8'h00;
      if (w_cfg_hs) r_cfg_done <= 1'b1;
      if (w_msg_hs)                  r_core_mode <= msg_mode;
      else if (w_res_hs || w_timeout) r_core_mode <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt <= 6'd0;
      r_res    <= '0;
    end else begin
      if (r_state != RX)  r_rx_cnt <= 6'd0;
      else if (w_capture) r_rx_cnt <= r_rx_cnt + 6'd1;
      if (w_timeout) begin
        r_res <= '0;
      end else if (w_capture) begin
        if (r_rx_cnt < 6'(CIPHER_BYTES)) r_res.cipher[{r_rx_cnt[3:0], 3'b000} +: 8] <= core_odata;
        else                             r_res.tag[{w_tag_idx, 3'b000} +: 8]       <= core_odata;
      end
    end
  end

`ifdef HOSTIF_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_err;
  logic        w_wait_st;

  assign w_wait_st = (r_state == KDF_WAIT_HI) || (r_state == KDF_WAIT_LO) || (r_state == RX);
  assign w_timeout = w_wait_st && !w_capture && (r_wdog == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= 16'd0;
      r_err  <= 1'b0;
    end else begin
      if (!w_wait_st || w_capture || (w_state_nxt != r_state)) r_wdog <= 16'd0;
      else                                                     r_wdog <= r_wdog + 16'd1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign err       = 1'b0;
`endif

  assign cfg_ready  = r_cfg_ready;
  assign msg_ready  = r_msg_ready;
  assign res_valid  = r_res_valid;
  assign res_cipher = r_res.cipher;
  assign res_tag    = r_res.tag;
  assign core_data  = r_core_data;
  assign core_start = r_core_start;
  assign core_mode  = r_core_mode;

endmodule

// File: doc/aes_sha3_host_if.md
Name: aes_sha3_host_if

Overview:
- Host-side byte-stream master for the AES/SHA3 crypto core's 8-bit serial interface.
- Transmit direction: serializes a 256-bit salt/key word and 128-bit message blocks into core byte strobes.
- Receive direction: deserializes the core's 16-byte cipher and 32-byte HMAC tag into one parallel result word.
- Sits between a word-level valid/ready host bus and the core's i_data/i_start/o_ien/o_data/o_valid pins.

Parameters:
- TIMEOUT_CYCLES, 4096: watchdog limit per wait state. Used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  salt/key word offered.
- cfg_ready  out  1  salt/key accepted this cycle.
- cfg_salt_key  in  256  salt in [255:128], key in [127:0].
- msg_valid  in  1  message block offered.
- msg_ready  out  1  message accepted this cycle.
- msg_data  in  128  plaintext/ciphertext block.
- msg_mode  in  1  AES direction for this block.
- res_valid  out  1  result held until accepted.
- res_ready  in  1  host accepts result.
- res_cipher  out  128  byte i at [8i+7:8i], i = receive order.
- res_tag  out  256  byte i at [8i+7:8i], i = receive order.
- core_data  out  8  to core i_data.
- core_start  out  1  to core i_start; high marks a valid byte.
- core_mode  out  1  to core i_mode.
- core_ien  in  1  from core o_ien; low means the core accepts input.
- core_odata  in  8  from core o_data.
- core_ovalid  in  1  from core o_valid.
- err  out  1  sticky timeout flag; constant 0 without the feature.

Behaviour:
- Reset values: all outputs 0; state = IDLE; counters = 0.
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high. Reset mid-operation aborts immediately to IDLE. The core shares the same reset, via inversion at top level.
- All outputs are registered.
- States: IDLE, KEY_TX, KDF_WAIT_HI, KDF_WAIT_LO, MSG_WAIT, MSG_TX, RX, RESULT.
- IDLE:
  - cfg_ready = 1 only in IDLE, and only while core_ien = 0.
  - On cfg_valid & cfg_ready: latch the word, go to KEY_TX, byte counter = 0.
  - cfg is accepted once per reset. After that, cfg_ready stays 0 (the core has no re-key path).
- KEY_TX:
  - core_start = 1 for exactly 32 consecutive cycles.
  - core_data = cfg_salt_key MSB byte first: [255:248], then down to [7:0].
  - After the 32nd byte, go to KDF_WAIT_HI.
- KDF_WAIT_HI: wait for core_ien = 1, then go to KDF_WAIT_LO.
- KDF_WAIT_LO: wait for core_ien = 0 (key derivation done), then go to MSG_WAIT.
- MSG_WAIT:
  - msg_ready = 1 iff core_ien = 0 and res_valid = 0.
  - On handshake: latch msg_data and msg_mode, go to MSG_TX.
- MSG_TX:
  - 16 consecutive core_start cycles, MSB byte first.
  - core_mode holds the latched mode from msg accept until the RESULT handshake.
  - After the 16th byte, go to RX with rx counter = 0.
- RX:
  - Each cycle core_ovalid = 1 captures core_odata at index rx counter, then increments the counter.
  - Indices 0–15 go to res_cipher; indices 16–47 go to res_tag.
  - core_ovalid gaps (including the one-cycle gap between cipher and tag) are tolerated and skipped.
  - After index 47 is captured: res_valid = 1 on the next cycle, go to RESULT.
- RESULT:
  - res_valid and res_* are held stable until res_ready.
  - On handshake: res_valid = 0, go to MSG_WAIT.
  - The next msg may be accepted no earlier than the cycle after the handshake.
- Simultaneous events:
  - msg_valid during RX or RESULT is ignored (msg_ready = 0).
  - core_ovalid outside RX is ignored.
  - core_ien rising in MSG_TX before the 16th byte is a core fault; byte transmission continues regardless.
- Counters are 6-bit and never wrap in normal flow. Each counter is cleared on entry to its state.

Optional Feature:
- Macro: HOSTIF_TIMEOUT_EN.
- With it defined:
  - A 16-bit watchdog counts cycles in KDF_WAIT_HI, KDF_WAIT_LO and RX; it is cleared on every state change and on every captured byte.
  - On reaching TIMEOUT_CYCLES: err = 1 (sticky until rst), go to IDLE, drop partial results, keep cfg accepted.
  - After a timeout only msg traffic is possible, via MSG_WAIT once core_ien = 0.
- Without it: no watchdog logic; err tied 0.

Decomposition:
- Shared package: state enum, byte-count constants (KEY_BYTES = 32, MSG_BYTES = 16, CIPHER_BYTES = 16, TAG_BYTES = 32), and the result struct {cipher, tag}.
- One sub-module: hostif_byte_ser, a width-parameterized parallel-to-serial shifter with load/shift/last. It is instantiated for both the key and message paths, or shared.
- The deserializer stays inline.

Test Plan:
- Reset then cfg_salt_key = 256'h00010203…1F -> core_start high 32 cycles, core_data = 0x00, 0x01, … 0x1F in order; cfg_ready pulses once.
- Core model holds ien = 1 for 50 cycles then 0 -> msg_ready rises exactly one cycle after core_ien falls, not before.
- msg_data = 128'h00112233…FF, mode = 1 -> 16 bytes 0x00 … 0xFF on core_data; core_mode = 1 throughout.
- Core returns bytes 0xA0 … 0xAF, a 1-cycle gap, then 0xB0 … 0xCF -> res_cipher[7:0] = A0, [127:120] = AF; res_tag[7:0] = B0, [255:248] = CF.
- res_ready held low 20 cycles -> res_* stable, msg_ready = 0; after handshake a second message flows.
- Assert rst during MSG_TX byte 7 -> all outputs 0 asynchronously, state IDLE. With HOSTIF_TIMEOUT_EN and TIMEOUT_CYCLES = 64, stall in RX -> err = 1 at cycle 64.
